// File: rtl/chess_ctrl_pkg.sv
// Shared constants and FSM encoding for the chess controller move-list path.
// Slot layout: {invalid, move[17:0]}, eight slots per LMG FIFO word.
package chess_ctrl_pkg;

    localparam int MOVE_W     = 18;
    localparam int SLOT_W     = 19;
    localparam int SLOTS      = 8;
    localparam int WORD_W     = SLOTS * SLOT_W;
    localparam int COUNT_ADDR = 16;
    localparam int BASE_ADDR  = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LMG,
        S_POP,
        S_LATCH,
        S_SCAN,
        S_WR_COUNT,
        S_WR_TERM,
        S_DONE
    } state_e;

endpackage

// File: rtl/move_list_writer_if.sv
// LMG FIFO read side and RAM write side of the move-list writer.
// master = writer, slave = FIFO/RAM environment.
interface move_list_writer_if #(
    parameter int ADDR_WIDTH = 15
);
    import chess_ctrl_pkg::*;

    logic                  lmg_done;
    logic                  fifo_empty;
    logic [WORD_W-1:0]     fifo_data;
    logic                  fifo_rden;
    logic                  ram_wren;
    logic [ADDR_WIDTH-1:0] ram_wraddr;
    logic [31:0]           ram_data;

    modport master (
        input  lmg_done,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rden,
        output ram_wren,
        output ram_wraddr,
        output ram_data
    );

    modport slave (
        output lmg_done,
        output fifo_empty,
        output fifo_data,
        input  fifo_rden,
        input  ram_wren,
        input  ram_wraddr,
        input  ram_data
    );

endinterface

// File: rtl/lmg_slot_select.sv
// Picks one {invalid, move} slot out of a latched LMG FIFO word.
// Purely combinational.
module lmg_slot_select
    import chess_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [2:0]        idx_i,
    output logic              invalid_o,
    output logic [MOVE_W-1:0] move_o
);

    logic [SLOT_W-1:0] slot;

    assign slot      = word_i[idx_i * SLOT_W +: SLOT_W];
    assign invalid_o = slot[SLOT_W-1];
    assign move_o    = slot[MOVE_W-1:0];

endmodule

// File: rtl/move_list_writer.sv
// Drains LMG FIFO words into RAM as a move list, then writes the count
// word and a zero terminator.
module move_list_writer #(
    parameter int ADDR_WIDTH = 15,
    parameter int COUNT_ADDR = chess_ctrl_pkg::COUNT_ADDR,
    parameter int BASE_ADDR  = chess_ctrl_pkg::BASE_ADDR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    move_list_writer_if.master bus,
    output logic               busy,
    output logic               done,
    output logic [7:0]         move_count,
    output logic               overflow
);
    import chess_ctrl_pkg::*;

    state_e                state_q, state_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [2:0]            slot_q, slot_d;
    logic [7:0]            count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  seen_q, seen_d;

    logic                  slot_inv;
    logic [MOVE_W-1:0]     slot_move;
    logic [ADDR_WIDTH-1:0] list_addr;

    logic                  rden;
    logic                  wren;
    logic [ADDR_WIDTH-1:0] wraddr;
    logic [31:0]           wdata;

    lmg_slot_select u_sel (
        .word_i    (word_q),
        .idx_i     (slot_q),
        .invalid_o (slot_inv),
        .move_o    (slot_move)
    );

    assign list_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(count_q);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        slot_d  = slot_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        seen_d  = seen_q;
        rden    = 1'b0;
        wren    = 1'b0;
        wraddr  = '0;
        wdata   = '0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WAIT_LMG;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_WAIT_LMG: begin
                if (bus.lmg_done) begin
                    state_d = bus.fifo_empty ? S_WR_COUNT : S_POP;
                end
            end
            S_POP: begin
                rden    = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                word_d  = bus.fifo_data;
                slot_d  = '0;
                seen_d  = 1'b0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                slot_d = slot_q + 3'd1;
                if (!slot_inv) begin
                    seen_d = 1'b1;
                    // A full list drops further moves instead of wrapping
                    if (count_q == 8'hFF) begin
                        ovf_d = 1'b1;
                    end else begin
                        wren    = 1'b1;
                        wraddr  = list_addr;
                        wdata   = {14'b0, slot_move};
                        count_d = count_q + 8'd1;
                    end
                end
                if (slot_q == 3'd7) begin
                    state_d = (seen_d && !bus.fifo_empty) ? S_POP : S_WR_COUNT;
                end
            end
            S_WR_COUNT: begin
                wren    = 1'b1;
                wraddr  = ADDR_WIDTH'(COUNT_ADDR);
                wdata   = {23'b0, ovf_q, count_q};
                state_d = S_WR_TERM;
            end
            S_WR_TERM: begin
                wren    = 1'b1;
                wraddr  = list_addr;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            slot_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            slot_q  <= slot_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            seen_q  <= seen_d;
        end
    end

    assign bus.fifo_rden  = rden;
    assign bus.ram_wren   = wren;
    assign bus.ram_wraddr = wraddr;
    assign bus.ram_data   = wdata;

    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign move_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_move_list_writer.sv
// Directed bench for move_list_writer with a small FIFO model and a
// RAM write log.
module tb_move_list_writer;
    import chess_ctrl_pkg::*;

    localparam int AW = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [7:0] move_count;

    int checks = 0;
    int errors = 0;

    move_list_writer_if #(.ADDR_WIDTH(AW)) bus ();

    move_list_writer #(
        .ADDR_WIDTH (AW),
        .COUNT_ADDR (16),
        .BASE_ADDR  (17)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .move_count (move_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0] mem [0:127];
    int wr_n = 0;
    int rd_n = 0;
    int cyc = 0;

    logic [AW-1:0] log_a[$];
    logic [31:0]   log_d[$];
    int            log_c[$];

    assign bus.fifo_empty = (rd_n == wr_n);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rden === 1'b1) begin
            bus.fifo_data <= mem[rd_n];
            rd_n <= rd_n + 1;
        end
    end

    always @(negedge clk) begin
        if (bus.ram_wren === 1'b1) begin
            log_a.push_back(bus.ram_wraddr);
            log_d.push_back(bus.ram_data);
            log_c.push_back(cyc);
        end
    end

    function automatic logic [WORD_W-1:0] mk_word(input logic [7:0] vmask,
                                                 input int first);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (vmask[k])
                w[k*SLOT_W +: SLOT_W] = {1'b0, 18'(first + k)};
            else
                w[k*SLOT_W +: SLOT_W] = {1'b1, 18'h0};
        end
        return w;
    endfunction

    task automatic push_word(input logic [WORD_W-1:0] w);
        mem[wr_n] = w;
        wr_n++;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout done=%b want 1", name, done);
        end
    endtask

    task automatic test_reset();
        bus.lmg_done = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, move_count, overflow, bus.fifo_rden, bus.ram_wren,
             bus.ram_wraddr, bus.ram_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b cnt=%0d ovf=%b rden=%b wren=%b want all 0",
                     busy, done, move_count, overflow, bus.fifo_rden, bus.ram_wren);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty();
        int b;
        b = log_a.size();
        bus.lmg_done = 1'b1;
        pulse_start();
        wait_done("empty");
        checks++;
        if (log_a.size() != b + 2) begin
            errors++;
            $display("FAIL empty_nwrites got %0d want 2", log_a.size() - b);
        end else begin
            checks++;
            if (log_a[b] !== 15'd16 || log_d[b] !== 32'd0) begin
                errors++;
                $display("FAIL empty_count got @%0d=%h want @16=0", log_a[b], log_d[b]);
            end
            checks++;
            if (log_a[b+1] !== 15'd17 || log_d[b+1] !== 32'd0) begin
                errors++;
                $display("FAIL empty_term got @%0d=%h want @17=0", log_a[b+1], log_d[b+1]);
            end
        end
        checks++;
        if (move_count !== 8'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_status cnt=%0d ovf=%b busy=%b want 0 0 0", move_count, overflow, busy);
        end
    endtask

    task automatic test_full_word();
        int b;
        logic [AW-1:0] ea [10];
        logic [31:0]   ed [10];
        for (int i = 0; i < 8; i++) begin
            ea[i] = AW'(17 + i);
            ed[i] = 32'(1 + i);
        end
        ea[8] = 15'd16; ed[8] = 32'd8;
        ea[9] = 15'd25; ed[9] = 32'd0;
        push_word(mk_word(8'hFF, 1));
        push_word(mk_word(8'h00, 0));
        bus.lmg_done = 1'b0;
        b = log_a.size();
        pulse_start();
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || log_a.size() != b || bus.fifo_rden !== 1'b0) begin
            errors++;
            $display("FAIL wait_lmg busy=%b writes=%0d rden=%b want 1 0 0",
                     busy, log_a.size() - b, bus.fifo_rden);
        end
        bus.lmg_done = 1'b1;
        wait_done("full");
        checks++;
        if (log_a.size() != b + 10) begin
            errors++;
            $display("FAIL full_nwrites got %0d want 10", log_a.size() - b);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (log_a[b+i] !== ea[i] || log_d[b+i] !== ed[i]) begin
                    errors++;
                    $display("FAIL full_write%0d got @%0d=%h want @%0d=%h",
                             i, log_a[b+i], log_d[b+i], ea[i], ed[i]);
                end
            end
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (log_c[b+i+1] != log_c[b+i] + 1) begin
                    errors++;
                    $display("FAIL full_consec%0d gap got %0d want 1",
                             i, log_c[b+i+1] - log_c[b+i]);
                end
            end
        end
        checks++;
        if (move_count !== 8'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_status cnt=%0d ovf=%b want 8 0", move_count, overflow);
        end
    endtask

    task automatic test_sparse();
        int b;
        logic [AW-1:0] ea [4];
        logic [31:0]   ed [4];
        ea[0] = 15'd17; ed[0] = 32'h102;
        ea[1] = 15'd18; ed[1] = 32'h105;
        ea[2] = 15'd16; ed[2] = 32'd2;
        ea[3] = 15'd19; ed[3] = 32'd0;
        push_word(mk_word(8'b0010_0100, 'h100));
        b = log_a.size();
        pulse_start();
        wait_done("sparse");
        checks++;
        if (log_a.size() != b + 4) begin
            errors++;
            $display("FAIL sparse_nwrites got %0d want 4", log_a.size() - b);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_a[b+i] !== ea[i] || log_d[b+i] !== ed[i]) begin
                    errors++;
                    $display("FAIL sparse_write%0d got @%0d=%h want @%0d=%h",
                             i, log_a[b+i], log_d[b+i], ea[i], ed[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int b;
        for (int i = 0; i < 33; i++)
            push_word(mk_word(8'hFF, i * 8 + 1));
        b = log_a.size();
        pulse_start();
        wait_done("ovf");
        checks++;
        if (log_a.size() != b + 257) begin
            errors++;
            $display("FAIL ovf_nwrites got %0d want 257", log_a.size() - b);
        end else begin
            for (int j = 0; j < 255; j++) begin
                checks++;
                if (log_a[b+j] !== AW'(17 + j) || log_d[b+j] !== 32'(j + 1)) begin
                    errors++;
                    $display("FAIL ovf_write%0d got @%0d=%h want @%0d=%h",
                             j, log_a[b+j], log_d[b+j], 17 + j, j + 1);
                end
            end
            checks++;
            if (log_a[b+255] !== 15'd16 || log_d[b+255] !== 32'h1FF) begin
                errors++;
                $display("FAIL ovf_count got @%0d=%h want @16=1ff", log_a[b+255], log_d[b+255]);
            end
            checks++;
            if (log_a[b+256] !== 15'd272 || log_d[b+256] !== 32'd0) begin
                errors++;
                $display("FAIL ovf_term got @%0d=%h want @272=0", log_a[b+256], log_d[b+256]);
            end
        end
        checks++;
        if (move_count !== 8'd255 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_status cnt=%0d ovf=%b want 255 1", move_count, overflow);
        end
    endtask

    task automatic test_start_busy();
        int b;
        push_word(mk_word(8'hFF, 'h60));
        b = log_a.size();
        pulse_start();
        checks++;
        if (move_count !== 8'd0 || overflow !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_clear cnt=%0d ovf=%b done=%b want 0 0 0", move_count, overflow, done);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        wait_done("busy");
        checks++;
        if (log_a.size() != b + 10) begin
            errors++;
            $display("FAIL busy_nwrites got %0d want 10", log_a.size() - b);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_a[b+i] !== AW'(17 + i) || log_d[b+i] !== 32'('h60 + i)) begin
                    errors++;
                    $display("FAIL busy_write%0d got @%0d=%h want @%0d=%h",
                             i, log_a[b+i], log_d[b+i], 17 + i, 'h60 + i);
                end
            end
            checks++;
            if (log_a[b+8] !== 15'd16 || log_d[b+8] !== 32'd8) begin
                errors++;
                $display("FAIL busy_count got @%0d=%h want @16=8", log_a[b+8], log_d[b+8]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b;
        int n;
        push_word(mk_word(8'hFF, 'h40));
        pulse_start();
        n = 0;
        while (!(bus.ram_wren === 1'b1 && bus.ram_wraddr === 15'd20) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.ram_wren !== 1'b1 || bus.ram_wraddr !== 15'd20) begin
            errors++;
            $display("FAIL mid_slot3 wren=%b addr=%0d want 1 20", bus.ram_wren, bus.ram_wraddr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, move_count, overflow, bus.fifo_rden, bus.ram_wren,
             bus.ram_wraddr, bus.ram_data} !== '0) begin
            errors++;
            $display("FAIL mid_reset busy=%b done=%b cnt=%0d ovf=%b wren=%b addr=%0d want all 0",
                     busy, done, move_count, overflow, bus.ram_wren, bus.ram_wraddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_word(mk_word(8'hFF, 'h50));
        b = log_a.size();
        pulse_start();
        wait_done("mid");
        checks++;
        if (log_a.size() != b + 10) begin
            errors++;
            $display("FAIL mid_nwrites got %0d want 10", log_a.size() - b);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_a[b+i] !== AW'(17 + i) || log_d[b+i] !== 32'('h50 + i)) begin
                    errors++;
                    $display("FAIL mid_write%0d got @%0d=%h want @%0d=%h",
                             i, log_a[b+i], log_d[b+i], 17 + i, 'h50 + i);
                end
            end
            checks++;
            if (log_a[b+8] !== 15'd16 || log_d[b+8] !== 32'd8 ||
                log_a[b+9] !== 15'd25 || log_d[b+9] !== 32'd0) begin
                errors++;
                $display("FAIL mid_tail got @%0d=%h @%0d=%h want @16=8 @25=0",
                         log_a[b+8], log_d[b+8], log_a[b+9], log_d[b+9]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_full_word();
        test_sparse();
        test_overflow();
        test_start_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
